// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer
// Self-test front end for the 8-function NAND-built logic unit. A run walks
// all 32 {sel, a, b} combinations in ascending order. Each combination is
// held for SETTLE cycles, and the unit's answer is sampled on the last edge
// of that window. The answer is stored in result and checked against the
// golden truth table. The block counts mismatches and remembers the first
// failing step.
module logic_op_sequencer #(
    parameter int SETTLE = 1            // cycles per step, legal 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic        unit_out,
    output logic        a,
    output logic        b,
    output logic [2:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [5:0]  err_cnt,
    output logic [4:0]  first_err_idx
);

    // Bit i holds the expected unit result for step i, where step i uses
    // sel = i[4:2], a = i[1], b = i[0]. The functions by sel are:
    // NAND, AND, OR, NOR, XOR, XNOR, NOT a, NOT a.
    localparam logic [31:0] GOLDEN      = 32'h33961E87;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [4:0]  idx_reg;   // current step
    logic [3:0]  cnt_reg;   // settle counter within the current step

    // Sequencer FSM with registered operand, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= 5'd0;
            cnt_reg       <= 4'd0;
            a             <= 1'b0;
            b             <= 1'b0;
            sel           <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= 32'd0;
            err_cnt       <= 6'd0;
            first_err_idx <= 5'd0;
        end else begin
            // done is high only for the cycle spent in DONE
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The operands keep their last values while idle.
                    if (start) begin
                        result        <= 32'd0;
                        err_cnt       <= 6'd0;
                        first_err_idx <= 5'd0;
                        idx_reg       <= 5'd0;
                        cnt_reg       <= 4'd0;
                        {sel, a, b}   <= 5'd0;
                        busy          <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    // While hold is high, the step and counter stay frozen.
                    if (!hold) begin
                        if (cnt_reg == SETTLE_LAST) begin
                            cnt_reg         <= 4'd0;
                            result[idx_reg] <= unit_out;
                            if (unit_out != GOLDEN[idx_reg]) begin
                                err_cnt <= err_cnt + 6'd1;
                                // A zero count means no mismatch so far in this run.
                                if (err_cnt == 6'd0) begin
                                    first_err_idx <= idx_reg;
                                end
                            end
                            if (idx_reg == 5'd31) begin
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                idx_reg     <= idx_reg + 5'd1;
                                {sel, a, b} <= idx_reg + 5'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // A start request in this cycle is dropped.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Testbench for logic_op_sequencer. It drives two instances: dut1 with
// SETTLE = 1 and dut2 with SETTLE = 2. Each instance is connected to a
// behavioural logic unit that can be ideal, stuck at 0, or inverted at step 13.
// The stimulus queues the expected run outcome when it starts a run. A separate
// monitor pops that entry and checks it on every done pulse.
module tb_logic_op_sequencer;

    localparam logic [31:0] GOLD  = 32'h33961E87;
    localparam logic [31:0] GOLD13 = 32'h33963E87;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start1 = 1'b0, hold1 = 1'b0, start2 = 1'b0, hold2 = 1'b0;
    logic        uo1, uo2;
    logic        a1, b1, a2, b2, busy1, busy2, done1, done2;
    logic [2:0]  sel1, sel2;
    logic [31:0] result1, result2;
    logic [5:0]  err1, err2;
    logic [4:0]  first1, first2;
    int          mode1 = 0, mode2 = 0;   // 0 ideal, 1 stuck-0, 2 invert step 13

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int bcnt1 = 0, bcnt2 = 0;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  err;
        logic [4:0]  first;
        int          lat;    // edges from E0 to the edge that samples done high
        int          e0;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_op_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1), .unit_out(uo1),
        .a(a1), .b(b1), .sel(sel1), .busy(busy1), .done(done1),
        .result(result1), .err_cnt(err1), .first_err_idx(first1)
    );

    logic_op_sequencer #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .hold(hold2), .unit_out(uo2),
        .a(a2), .b(b2), .sel(sel2), .busy(busy2), .done(done2),
        .result(result2), .err_cnt(err2), .first_err_idx(first2)
    );

    // Behavioural logic unit written from the function table
    function automatic logic unit_model(input int mode, input logic [2:0] s,
                                        input logic x, input logic y);
        logic v;
        case (s)
            3'd0: v = ~(x & y);
            3'd1: v = x & y;
            3'd2: v = x | y;
            3'd3: v = ~(x | y);
            3'd4: v = x ^ y;
            3'd5: v = ~(x ^ y);
            default: v = ~x;
        endcase
        if (mode == 1) v = 1'b0;
        if (mode == 2 && s == 3'd3 && !x && y) v = ~v;
        return v;
    endfunction

    assign uo1 = unit_model(mode1, sel1, a1, b1);
    assign uo2 = unit_model(mode2, sel2, a2, b2);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Busy cycle counters, cleared by each start request
    always @(negedge clk) begin
        if (busy1) bcnt1++;
        if (busy2) bcnt2++;
    end

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 result", result1, e.res);
                check("dut1 err_cnt", 32'(err1), 32'(e.err));
                check("dut1 first_err_idx", 32'(first1), 32'(e.first));
                check("dut1 done latency", 32'(cyc + 1 - e.e0), 32'(e.lat));
                check("dut1 busy cycles", 32'(bcnt1), 32'(e.lat - 1));
                check("dut1 busy low at done", 32'(busy1), 32'd0);
                $display("dut1 run: result=%h err_cnt=%0d first=%0d latency=%0d",
                         result1, err1, first1, cyc + 1 - e.e0);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("dut2 result", result2, e.res);
                check("dut2 err_cnt", 32'(err2), 32'(e.err));
                check("dut2 first_err_idx", 32'(first2), 32'(e.first));
                check("dut2 done latency", 32'(cyc + 1 - e.e0), 32'(e.lat));
                check("dut2 busy cycles", 32'(bcnt2), 32'(e.lat - 1));
                check("dut2 busy low at done", 32'(busy2), 32'd0);
                $display("dut2 run: result=%h err_cnt=%0d first=%0d latency=%0d",
                         result2, err2, first2, cyc + 1 - e.e0);
            end
        end
    end

    // Pulse start for one cycle and queue the expected outcome
    task automatic start_run(input int d, input logic [31:0] res, input logic [5:0] err,
                             input logic [4:0] first, input int lat);
        exp_t e;
        @(negedge clk);
        e.res = res; e.err = err; e.first = first; e.lat = lat; e.e0 = cyc + 1;
        if (d == 1) begin start1 = 1'b1; bcnt1 = 0; q1.push_back(e); end
        else        begin start2 = 1'b1; bcnt2 = 0; q2.push_back(e); end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        if (d == 1) begin
            check("dut1 busy after start", 32'(busy1), 32'd1);
            check("dut1 step0 operands", 32'({sel1, a1, b1}), 32'd0);
        end else begin
            check("dut2 busy after start", 32'(busy2), 32'd1);
            check("dut2 step0 operands", 32'({sel2, a2, b2}), 32'd0);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((d == 1) ? done1 : done2) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait for done within budget", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("expectation queue drained", 32'((d == 1) ? q1.size() : q2.size()), 32'd0);
    endtask

    task automatic wait_step(input int d, input logic [4:0] step, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (((d == 1) ? {sel1, a1, b1} : {sel2, a2, b2}) == step) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait for step within budget", 32'(seen), 32'd1);
    endtask

    initial begin
        // Apply reset with no clock edge in between, then check outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        check("reset dut1 outputs", {result1[26:0], err1[4:0]} | 32'({a1, b1, sel1, busy1, done1, first1, err1}), 32'd0);
        check("reset dut1 result", result1, 32'd0);
        check("reset dut2 busy/done", 32'({busy2, done2}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle without start busy", 32'(busy1), 32'd0);
        check("idle without start done", 32'(done1), 32'd0);

        // Run 1: ideal unit, SETTLE = 1
        mode1 = 0;
        start_run(1, GOLD, 6'd0, 5'd0, 33);
        wait_done(1, 200);
        check("idle holds last operands", 32'({sel1, a1, b1}), 32'd31);
        check("result held after done", result1, GOLD);

        // Run 2: unit stuck at 0
        mode1 = 1;
        start_run(1, 32'd0, 6'd16, 5'd0, 33);
        wait_done(1, 200);

        // Run 3: single inverted step 13
        mode1 = 2;
        start_run(1, GOLD13, 6'd1, 5'd13, 33);
        wait_done(1, 200);

        // Run 4: SETTLE = 2 with 5 hold cycles in step 10 and ignored starts
        mode2 = 0;
        start_run(2, GOLD, 6'd0, 5'd0, 64 + 5 + 1);
        wait_step(2, 5'd10, 200);
        hold2 = 1'b1;
        repeat (5) @(negedge clk);
        hold2 = 1'b0;
        check("operands frozen during hold", 32'({sel2, a2, b2}), 32'd10);
        for (int k = 0; k < 3; k++) begin
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            repeat (4) @(negedge clk);
        end
        wait_done(2, 300);

        // Run 5: reset during step 20 of a faulty run, followed by a clean run
        mode1 = 2;
        start_run(1, GOLD13, 6'd1, 5'd13, 33);
        wait_step(1, 5'd20, 200);
        #1 rst_n = 1'b0;
        #1;
        q1.delete();
        check("mid-run reset operands", 32'({sel1, a1, b1}), 32'd0);
        check("mid-run reset busy/done", 32'({busy1, done1}), 32'd0);
        check("mid-run reset result", result1, 32'd0);
        check("mid-run reset err/first", 32'({err1, first1}), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after reset idle busy", 32'(busy1), 32'd0);
        mode1 = 0;
        start_run(1, GOLD, 6'd0, 5'd0, 33);
        wait_done(1, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
